// File: rtl/jt053246_pkg.sv
// Shared types and helpers for the 053246 sprite draw path.
package jt053246_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH0 = 2'd1,
    ST_FETCH1 = 2'd2,
    ST_DRAW   = 2'd3
  } draw_st_t;

  // Zoom step that advances exactly one source column per output pixel
  localparam logic [10:0] ZOOM_UNIT = 11'h040;
  localparam int          ROW_PIX   = 16;

  // Pick one 4bpp pixel from a 64-bit row; pixel 0 sits in bits [63:60]
  function automatic logic [3:0] pix_sel(input logic [63:0] row,
                                         input logic [3:0]  col,
                                         input logic        flip);
    logic [3:0]  idx;
    logic [63:0] sh;
    idx = col ^ {4{flip}};
    sh  = row << {idx, 2'b00};
    return sh[63:60];
  endfunction

endpackage

// File: rtl/jt053246_draw_zoom.sv
// Horizontal zoom accumulator: 11-bit fixed point, 6 fractional bits.
// acc[9:6] is the source column; a carry into acc[10] ends the slice.
module jt053246_draw_zoom #(
  parameter int ZW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          keep,
  input  logic [ZW-1:0] hzoom,
  input  logic          adv,
  output logic [3:0]    col,
  output logic          done
);

  logic [10:0] acc;
  logic [10:0] step;
  logic [10:0] sum;

  assign sum  = acc + step;
  assign col  = acc[9:6];
  assign done = sum[10];

  // Load start value and clamped step on a new request, then advance per pixel.
  // Keeping the previous slice drops the overflow bit, i.e. subtracts 0x400.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      step <= 11'd1;
    end else if (load) begin
      acc  <= keep ? {1'b0, acc[9:0]} : 11'd0;
      step <= (hzoom == '0) ? 11'd1 : 11'(hzoom);
    end else if (adv) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/jt053246_draw.sv
// Sprite line renderer: fetches one 16-pixel row slice and writes the
// zoomed, flipped, non-transparent pixels into the object line buffer.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for dr_start, dr_busy low
// ST_FETCH0 | ROM read of left word (pixels 0-7)
// ST_FETCH1 | ROM read of right word (pixels 8-15)
// ST_DRAW   | one output pixel per clk until the accumulator overflows
module jt053246_draw
  import jt053246_pkg::*;
#(
  parameter int ZW = 10,
  parameter int AW = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs,
  input  logic          dr_start,
  output logic          dr_busy,
  input  logic [15:0]   code,
  input  logic [9:0]    attr,
  input  logic [1:0]    shd,
  input  logic          hflip,
  input  logic          vflip,
  input  logic [9:0]    hpos,
  input  logic [3:0]    ysub,
  input  logic [11:0]   hzoom,
  input  logic          hz_keep,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,
  output logic [8:0]    buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic [7:0]    aborts
);

  draw_st_t    st;
  logic        hs_d;
  logic        hs_rise;
  logic        accept;
  logic [9:0]  attr_q;
  logic [1:0]  shd_q;
  logic        hflip_q;
  logic [9:0]  x_q;
  logic [63:0] row_q;
  logic [3:0]  col;
  logic        zdone;
  logic [3:0]  pix;
  logic        unused_hz;

  assign unused_hz = ^hzoom[11:ZW];
  assign hs_rise   = hs & ~hs_d;
  assign accept    = (st == ST_IDLE) && dr_start && !dr_busy && !hs_rise;
  assign pix       = pix_sel(row_q, col, hflip_q);

  jt053246_draw_zoom #(.ZW(ZW)) u_zoom (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .keep  (hz_keep),
    .hzoom (hzoom[ZW-1:0]),
    .adv   ((st == ST_DRAW) && !hs_rise),
    .col   (col),
    .done  (zdone)
  );

  // Request handshake, ROM fetch, pixel output and hs abort sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      hs_d     <= 1'b0;
      dr_busy  <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= '0;
      aborts   <= '0;
      attr_q   <= '0;
      shd_q    <= '0;
      hflip_q  <= 1'b0;
      x_q      <= '0;
      row_q    <= '0;
    end else begin
      hs_d   <= hs;
      buf_we <= 1'b0;
      if (hs_rise && st != ST_IDLE) begin
        st      <= ST_IDLE;
        dr_busy <= 1'b0;
        rom_cs  <= 1'b0;
        if (aborts != 8'hFF) aborts <= aborts + 8'd1;
      end else begin
        case (st)
          ST_IDLE: begin
            if (accept) begin
              attr_q   <= attr;
              shd_q    <= shd;
              hflip_q  <= hflip;
              x_q      <= hpos;
              rom_addr <= AW'({code, ysub ^ {4{vflip}}, 1'b0});
              rom_cs   <= 1'b1;
              dr_busy  <= 1'b1;
              st       <= ST_FETCH0;
            end
          end
          ST_FETCH0: begin
            if (rom_ok) begin
              row_q[63:32] <= rom_data;
              rom_addr[0]  <= 1'b1;
              st           <= ST_FETCH1;
            end
          end
          ST_FETCH1: begin
            if (rom_ok) begin
              row_q[31:0] <= rom_data;
              rom_cs      <= 1'b0;
              st          <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            buf_addr <= x_q[8:0];
            buf_din  <= {shd_q, attr_q, pix};
            buf_we   <= (pix != 4'd0) && !x_q[9];
            x_q      <= x_q + 10'd1;
            if (zdone) begin
              st      <= ST_IDLE;
              dr_busy <= 1'b0;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt053246_draw.sv
// Self-checking bench for jt053246_draw: vector table plus scoreboard.
module tb_jt053246_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic [1:0]  shd;
  logic        hflip, vflip;
  logic [9:0]  hpos;
  logic [3:0]  ysub;
  logic [11:0] hzoom;
  logic        hz_keep;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [8:0]  buf_addr;
  logic [15:0] buf_din;
  logic        buf_we;
  logic [7:0]  aborts;

  jt053246_draw dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .shd(shd), .hflip(hflip), .vflip(vflip),
    .hpos(hpos), .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .aborts(aborts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [9:0]  attr;
    logic [1:0]  shd;
    logic        hf, vf;
    logic [9:0]  hpos;
    logic [3:0]  ysub;
    logic [11:0] hz;
    logic        keep;
    logic [31:0] w0, w1;
    int          wt;
    int          n_exp;
  } vec_t;

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  vec_t        vt[10];
  wr_t         wq[$];
  logic [20:0] aq[$];
  int          nchk = 0;
  int          nerr = 0;
  int          macc = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] cur_w0, cur_w1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ROM model: word selected by address LSB, ok after wait_cfg cycles per word
  assign rom_data = rom_addr[0] ? cur_w1 : cur_w0;
  assign rom_ok   = rom_cs && (wcnt == 0);
  always @(posedge clk) begin
    if (!rom_cs)     wcnt <= wait_cfg;
    else if (rom_ok) wcnt <= wait_cfg;
    else if (wcnt > 0) wcnt <= wcnt - 1;
  end

  // Scoreboard: pop expected ROM addresses and line buffer writes
  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_we) begin
        if (wq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL extra_write: got addr %0h din %0h want none", buf_addr, buf_din);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("buf_addr", buf_addr, e.a);
          chk("buf_din", buf_din, e.d);
        end
      end
      if (rom_cs && rom_ok) begin
        if (aq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL extra_rom: got addr %0h want none", rom_addr);
        end else begin
          chk("rom_addr", rom_addr, aq.pop_front());
        end
      end
    end
  end

  function automatic logic [3:0] bpix(input logic [31:0] w0, input logic [31:0] w1, input int i);
    logic [31:0] w;
    w = (i < 8) ? w0 : w1;
    return 4'(w >> (28 - 4 * (i % 8)));
  endfunction

  // Drive one request and push its expected ROM reads and writes
  task automatic start(input int k);
    int acc, n, step, x, c;
    logic [3:0] p;
    @(negedge clk);
    code = vt[k].code; attr = vt[k].attr; shd = vt[k].shd;
    hflip = vt[k].hf; vflip = vt[k].vf; hpos = vt[k].hpos;
    ysub = vt[k].ysub; hzoom = vt[k].hz; hz_keep = vt[k].keep;
    cur_w0 = vt[k].w0; cur_w1 = vt[k].w1; wait_cfg = vt[k].wt;
    aq.push_back({vt[k].code, vt[k].ysub ^ {4{vt[k].vf}}, 1'b0});
    aq.push_back({vt[k].code, vt[k].ysub ^ {4{vt[k].vf}}, 1'b1});
    step = int'(vt[k].hz) % 1024;
    if (step == 0) step = 1;
    acc = vt[k].keep ? macc - 1024 : 0;
    n = 0;
    while (acc < 1024) begin
      x = (int'(vt[k].hpos) + n) % 1024;
      c = acc / 64;
      if (vt[k].hf) c = 15 - c;
      p = bpix(vt[k].w0, vt[k].w1, c);
      if (p != 0 && x < 512) wq.push_back({9'(x), vt[k].shd, vt[k].attr, p});
      n++;
      acc += step;
    end
    macc = acc;
    dr_start = 1'b1;
  endtask

  // Hold dr_start for two clocks, measure busy length, drain scoreboard
  task automatic finish(input int k);
    int cyc;
    bit ok;
    @(negedge clk);
    chk("accept_busy", dr_busy, 1);
    cyc = 1;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      dr_start = 1'b0;
      if (!dr_busy) begin ok = 1; break; end
      cyc++;
    end
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL busy_timeout: got busy stuck want fall (vec %0d)", k);
    end
    chk("busy_len", cyc, 2 + vt[k].n_exp + 2 * vt[k].wt);
    repeat (2) @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("rom_left", aq.size(), 0);
  endtask

  initial begin
    int nw;
    vt[0] = '{16'h0123, 10'h155, 2'b01, 0, 0, 10'h040, 4'd5, 12'h040, 0, 32'h11111111, 32'h22222222, 0, 16};
    vt[1] = '{16'h0123, 10'h155, 2'b01, 1, 1, 10'h040, 4'd5, 12'h040, 0, 32'h11111111, 32'h22222222, 0, 16};
    vt[2] = '{16'h0ABC, 10'h2AA, 2'b10, 0, 0, 10'h040, 4'd3, 12'hC80, 0, 32'h12345678, 32'h9ABCDEF1, 0, 8};
    vt[3] = '{16'h0ABC, 10'h0F0, 2'b11, 0, 0, 10'h040, 4'd3, 12'h020, 0, 32'h12345678, 32'h9ABCDEF1, 1, 32};
    vt[4] = '{16'h7FFF, 10'h3FF, 2'b00, 0, 1, 10'h100, 4'd0, 12'h040, 0, 32'h10203040, 32'h0A0B0C00, 2, 16};
    vt[5] = '{16'h0001, 10'h001, 2'b01, 0, 0, 10'h3F8, 4'd9, 12'h040, 0, 32'h12345678, 32'h9ABCDEF1, 0, 16};
    vt[6] = '{16'hFFFF, 10'h123, 2'b10, 0, 0, 10'h100, 4'hF, 12'h000, 0, 32'h12345678, 32'h9ABCDEF1, 0, 1024};
    vt[7] = '{16'h0040, 10'h005, 2'b00, 0, 0, 10'h040, 4'd1, 12'h030, 0, 32'h12345678, 32'h9ABCDEF1, 0, 22};
    vt[8] = '{16'h0041, 10'h005, 2'b00, 0, 0, 10'h056, 4'd1, 12'h030, 1, 32'h87654321, 32'h1FEDCBA9, 0, 21};
    vt[9] = '{16'h1234, 10'h200, 2'b11, 1, 0, 10'h1FA, 4'd7, 12'h05B, 0, 32'h12345678, 32'h9ABCDEF1, 1, 12};

    rst_n = 1'b0; hs = 1'b0; dr_start = 1'b0;
    code = '0; attr = '0; shd = '0; hflip = 0; vflip = 0; hpos = '0;
    ysub = '0; hzoom = '0; hz_keep = 0; cur_w0 = '0; cur_w1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", dr_busy, 0);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_buf_we", buf_we, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_din", buf_din, 0);
    chk("rst_aborts", aborts, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      start(k);
      finish(k);
    end

    // hs abort after five written pixels
    start(0);
    @(negedge clk);
    @(negedge clk);
    dr_start = 1'b0;
    nw = 0;
    for (int t = 0; t < 100 && nw < 5; t++) begin
      @(negedge clk);
      if (buf_we) nw++;
    end
    chk("abort_reach5", nw, 5);
    hs = 1'b1;
    @(negedge clk);
    chk("abort_busy", dr_busy, 0);
    chk("abort_rom_cs", rom_cs, 0);
    chk("abort_count", aborts, 1);
    @(negedge clk);
    chk("abort_buf_we", buf_we, 0);
    chk("abort_unwritten", wq.size(), 11);
    wq.delete();
    aq.delete();

    // hs rise with dr_start while idle: request ignored, not an abort
    hs = 1'b0;
    @(negedge clk);
    hs = 1'b1;
    dr_start = 1'b1;
    @(negedge clk);
    chk("hs_start_busy", dr_busy, 0);
    chk("hs_idle_aborts", aborts, 1);
    dr_start = 1'b0;
    hs = 1'b0;
    @(negedge clk);

    start(0);
    finish(0);

    // reset in the middle of drawing
    start(0);
    nw = 0;
    for (int t = 0; t < 100 && nw < 2; t++) begin
      @(negedge clk);
      dr_start = 1'b0;
      if (buf_we) nw++;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", dr_busy, 0);
    chk("mid_rst_buf_we", buf_we, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_aborts", aborts, 0);
    wq.delete();
    aq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(1);
    finish(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
